// File: rtl/addr_unit.sv
// rtl/addr_unit.sv - address generation: PC, MAR, SP and stack write port (optional STACK_CHECK_EN bounds checking)
module addr_unit #(
    parameter int ADDR_W      = 12,
    parameter int SP_INIT     = 0,
    parameter int STACK_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_rst,
    input  logic [20:0]       ctrl,
    input  logic [15:0]       data_in,
    input  logic [15:0]       a_in,
    output logic [ADDR_W-1:0] mar_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stk_we,
    output logic [ADDR_W-1:0] stk_addr,
    output logic [15:0]       stk_wdata,
    output logic              stk_err
);

    // Control word bit positions as defined by the controller
    localparam int B_PC_INC      = 2;
    localparam int B_PC_LOAD     = 3;
    localparam int B_MAR_EN      = 4;
    localparam int B_MAR_LOAD    = 8;
    localparam int B_SP_ADD      = 10;
    localparam int B_MAR_STACK   = 11;
    localparam int B_STACK_LOAD  = 12;
    localparam int B_PC_MAR_LOAD = 13;
    localparam int B_MAR_INC     = 14;
    localparam int B_MAR_A_LOAD  = 18;
    localparam int B_JUMP        = 19;

    localparam logic [ADDR_W-1:0] SP_RST = SP_INIT[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] TWO    = {{(ADDR_W-2){1'b0}}, 2'b10};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] load_val;
    logic              push, pop, ovf, unf;

    // Bits the controller drives that this stage does not act on
    logic unused_inputs;
    assign unused_inputs = ^{ctrl[20], ctrl[17:15], ctrl[9], ctrl[7:5], ctrl[1:0],
                             data_in[15:ADDR_W], STACK_DEPTH};

    assign load_val = data_in[ADDR_W-1:0];
    assign push     = ctrl[B_STACK_LOAD];
    assign pop      = ctrl[B_SP_ADD];

`ifdef STACK_CHECK_EN
    localparam logic [ADDR_W-1:0] SP_FULL = SP_RST - STACK_DEPTH[ADDR_W-1:0];
    // A lone push at the full mark or a lone pop at the empty mark is rejected
    always_comb begin
        ovf   = push & ~pop & (sp_q == SP_FULL);
        unf   = pop & ~push & (sp_q == SP_RST);
        err_d = err_q | ovf | unf;
    end
`else
    // Without checking the stack wraps freely and never flags
    always_comb begin
        ovf   = 1'b0;
        unf   = 1'b0;
        err_d = 1'b0;
    end
`endif

    // Next-state selection for PC, MAR and SP in priority order
    always_comb begin
        pc_d = pc_q;
        if (ctrl[B_PC_LOAD])      pc_d = load_val;
        else if (ctrl[B_JUMP])    pc_d = pc_q + TWO;
        else if (ctrl[B_PC_INC])  pc_d = pc_q + ONE;

        mar_d = mar_q;
        if (ctrl[B_MAR_LOAD])          mar_d = load_val;
        else if (ctrl[B_MAR_A_LOAD])   mar_d = a_in[ADDR_W-1:0];
        else if (ctrl[B_MAR_STACK])    mar_d = sp_q;
        else if (ctrl[B_PC_MAR_LOAD])  mar_d = pc_q;
        else if (ctrl[B_JUMP])         mar_d = mar_q + TWO;
        else if (ctrl[B_MAR_INC])      mar_d = mar_q + ONE;

        sp_d = sp_q;
        if (push & ~pop & ~ovf)       sp_d = sp_q - ONE;
        else if (pop & ~push & ~unf)  sp_d = sp_q + ONE;
    end

    // Stack write port: pushes the return address on CAL, the accumulator otherwise
    always_comb begin
        stk_we    = push & ~ovf & ~soft_rst;
        stk_addr  = sp_q - ONE;
        stk_wdata = ctrl[B_MAR_EN] ? {{(16-ADDR_W){1'b0}}, mar_q} : a_in;
    end

    // State registers; soft reset overrides every control bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            mar_q <= '0;
            sp_q  <= SP_RST;
            err_q <= 1'b0;
        end else if (soft_rst) begin
            pc_q  <= '0;
            mar_q <= '0;
            sp_q  <= SP_RST;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign pc_out  = pc_q;
    assign mar_out = mar_q;
    assign sp_out  = sp_q;
    assign stk_err = err_q;

endmodule

// File: tb/tb_addr_unit.sv
// tb/tb_addr_unit.sv - randomized and directed self-checking bench for addr_unit
module tb_addr_unit;

    localparam int AW    = 12;
    localparam int SPI   = 0;
    localparam int DEPTH = 2;
`ifdef STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [20:0] PC_INC  = 21'd1 << 2;
    localparam logic [20:0] PC_LD   = 21'd1 << 3;
    localparam logic [20:0] MAR_EN  = 21'd1 << 4;
    localparam logic [20:0] MAR_LD  = 21'd1 << 8;
    localparam logic [20:0] SP_ADD  = 21'd1 << 10;
    localparam logic [20:0] STK_LD  = 21'd1 << 12;
    localparam logic [20:0] PC_MAR  = 21'd1 << 13;
    localparam logic [20:0] MAR_INC = 21'd1 << 14;
    localparam logic [20:0] JUMP    = 21'd1 << 19;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          soft_rst = 1'b0;
    logic [20:0]   ctrl = '0;
    logic [15:0]   data_in = '0;
    logic [15:0]   a_in = '0;
    logic [AW-1:0] mar_out, pc_out, sp_out, stk_addr;
    logic          stk_we, stk_err;
    logic [15:0]   stk_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state held as plain integers
    int m_pc, m_mar, m_sp;
    bit m_err;

    logic        we_s;
    logic [11:0] addr_s;
    logic [15:0] wd_s;

    addr_unit #(.ADDR_W(AW), .SP_INIT(SPI), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .soft_rst(soft_rst), .ctrl(ctrl),
        .data_in(data_in), .a_in(a_in), .mar_out(mar_out), .pc_out(pc_out),
        .sp_out(sp_out), .stk_we(stk_we), .stk_addr(stk_addr),
        .stk_wdata(stk_wdata), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int wrap(input int v);
        return ((v % 4096) + 4096) % 4096;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_sp = SPI; m_err = 1'b0;
    endtask

    task automatic check_regs();
        check("pc", 32'(pc_out), 32'(m_pc));
        check("mar", 32'(mar_out), 32'(m_mar));
        check("sp", 32'(sp_out), 32'(m_sp));
        check("err", 32'(stk_err), 32'(m_err));
    endtask

    // One controller cycle: drive on negedge, check strobe before posedge, registers after
    task automatic cyc(input logic [20:0] c, input logic [15:0] d, input logic [15:0] a, input logic s);
        bit push, pop, full, empty, exp_we;
        int ld, n_pc, n_mar, n_sp;
        @(negedge clk);
        ctrl = c; data_in = d; a_in = a; soft_rst = s;
        push  = c[12];
        pop   = c[10];
        full  = CHK && push && !pop && (m_sp == wrap(SPI - DEPTH));
        empty = CHK && pop && !push && (m_sp == SPI);
        exp_we = push && !full && !s;
        #2;
        we_s = stk_we; addr_s = stk_addr; wd_s = stk_wdata;
        check("stk_we", 32'(stk_we), 32'(exp_we));
        check("stk_addr", 32'(stk_addr), 32'(wrap(m_sp - 1)));
        check("stk_wdata", 32'(stk_wdata), c[4] ? 32'(m_mar) : 32'(a));
        @(posedge clk);
        #1;
        ld = int'(d) % 4096;
        n_pc = m_pc;
        if (c[3]) n_pc = ld;
        else if (c[19]) n_pc = wrap(m_pc + 2);
        else if (c[2]) n_pc = wrap(m_pc + 1);
        n_mar = m_mar;
        if (c[8]) n_mar = ld;
        else if (c[18]) n_mar = int'(a) % 4096;
        else if (c[11]) n_mar = m_sp;
        else if (c[13]) n_mar = m_pc;
        else if (c[19]) n_mar = wrap(m_mar + 2);
        else if (c[14]) n_mar = wrap(m_mar + 1);
        n_sp = m_sp;
        if (push && !pop && !full) n_sp = wrap(m_sp - 1);
        else if (pop && !push && !empty) n_sp = wrap(m_sp + 1);
        if (s) model_reset();
        else begin
            m_pc = n_pc; m_mar = n_mar; m_sp = n_sp;
            m_err = m_err | full | empty;
        end
        check_regs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_mar", 32'(mar_out), 32'h0);
        check("rst_sp", 32'(sp_out), 32'(SPI));
        check("rst_err", 32'(stk_err), 32'h0);
        reset = 1'b1;

        // Fetch
        cyc(PC_LD | MAR_LD, 16'h0005, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(PC_INC | MAR_INC, 16'h0, 16'h0, 1'b0);
        check("fetch_pc", 32'(pc_out), 32'h8);
        check("fetch_mar", 32'(mar_out), 32'h8);
        check("fetch_we", 32'(we_s), 32'h0);

        // Load beats increment
        cyc(PC_LD | MAR_LD | PC_INC | MAR_INC, 16'hB123, 16'h0, 1'b0);
        check("jump_pc", 32'(pc_out), 32'h123);
        check("jump_mar", 32'(mar_out), 32'h123);

        // CAL / RET
        cyc(MAR_LD, 16'h0041, 16'h0, 1'b0);
        cyc(PC_LD, 16'h0200, 16'h0, 1'b0);
        cyc(PC_MAR | STK_LD | MAR_EN, 16'h0, 16'h5555, 1'b0);
        check("cal_we", 32'(we_s), 32'h1);
        check("cal_addr", 32'(addr_s), 32'hFFF);
        check("cal_wdata", 32'(wd_s), 32'h0041);
        check("cal_sp", 32'(sp_out), 32'hFFF);
        check("cal_mar", 32'(mar_out), 32'h200);
        cyc(MAR_LD | PC_LD | PC_MAR | SP_ADD, 16'h0041, 16'h0, 1'b0);
        check("ret_pc", 32'(pc_out), 32'h041);
        check("ret_mar", 32'(mar_out), 32'h041);
        check("ret_sp", 32'(sp_out), 32'h0);

        // Skip and PC wrap
        cyc(PC_LD | MAR_LD, 16'd10, 16'h0, 1'b0);
        cyc(JUMP | PC_INC | MAR_INC, 16'h0, 16'h0, 1'b0);
        check("skip_pc", 32'(pc_out), 32'd12);
        check("skip_mar", 32'(mar_out), 32'd12);
        cyc(PC_LD, 16'h0FFF, 16'h0, 1'b0);
        cyc(JUMP, 16'h0, 16'h0, 1'b0);
        check("skip_wrap", 32'(pc_out), 32'h1);

        // Soft reset beats PC_LOAD
        cyc(PC_LD, 16'h0ABC, 16'h0, 1'b1);
        check("soft_pc", 32'(pc_out), 32'h0);

`ifdef STACK_CHECK_EN
        cyc(21'd0, 16'h0, 16'h0, 1'b1);
        cyc(STK_LD, 16'h0, 16'hAAAA, 1'b0);
        check("ovf_we1", 32'(we_s), 32'h1);
        check("ovf_a1", 32'(addr_s), 32'hFFF);
        cyc(STK_LD, 16'h0, 16'hAAAA, 1'b0);
        check("ovf_we2", 32'(we_s), 32'h1);
        check("ovf_a2", 32'(addr_s), 32'hFFE);
        cyc(STK_LD, 16'h0, 16'hAAAA, 1'b0);
        check("ovf_we3", 32'(we_s), 32'h0);
        check("ovf_sp", 32'(sp_out), 32'hFFE);
        check("ovf_err", 32'(stk_err), 32'h1);
        cyc(21'd0, 16'h0, 16'h0, 1'b1);
        cyc(SP_ADD, 16'h0, 16'h0, 1'b0);
        check("unf_sp", 32'(sp_out), 32'h0);
        check("unf_err", 32'(stk_err), 32'h1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            cyc(21'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 31) == 0);

        // Asynchronous reset in the middle of a CAL cycle
        cyc(PC_LD | MAR_LD, 16'h0777, 16'h0, 1'b0);
        cyc(STK_LD, 16'h0, 16'h1234, 1'b0);
        @(negedge clk);
        ctrl = PC_MAR | STK_LD | MAR_EN; soft_rst = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_pc", 32'(pc_out), 32'h0);
        check("arst_mar", 32'(mar_out), 32'h0);
        check("arst_sp", 32'(sp_out), 32'(SPI));
        check("arst_err", 32'(stk_err), 32'h0);
        ctrl = '0;
        #1 reset = 1'b1;
        cyc(PC_INC, 16'h0, 16'h0, 1'b0);
        check("post_arst_pc", 32'(pc_out), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addr_unit.md
Name: addr_unit

Overview:
- Address-generation stage directly downstream of the CPU controller; consumes its 21-bit control word and owns the program counter (PC), memory address register (MAR) and stack pointer (SP).
- Drives the RAM address and produces the stack write strobe/data for CAL and PSH.
- Registers update on posedge clk. The controller changes state on negedge, so the control word is stable at posedge.

Parameters:
- ADDR_W, 12, width of PC/MAR/SP and of the RAM address.
- SP_INIT, 0, SP value after reset. Push pre-decrements, so the first push writes address SP_INIT-1 (mod 2^ADDR_W).
- STACK_DEPTH, 256, maximum number of stacked words. Used only when STACK_CHECK_EN is defined.

Ports:
- clk  in  1  system clock, posedge active
- reset  in  1  asynchronous, active-low reset
- soft_rst  in  1  synchronous, active-high reset (controller RST instruction); same effect as reset, applied at posedge
- ctrl  in  21  controller control word; bit indices as defined in the controller
- data_in  in  16  RAM read data bus
- a_in  in  16  accumulator value
- mar_out  out  ADDR_W  RAM address (= MAR)
- pc_out  out  ADDR_W  program counter
- sp_out  out  ADDR_W  stack pointer
- stk_we  out  1  combinational stack write strobe
- stk_addr  out  ADDR_W  stack write address (= SP-1)
- stk_wdata  out  16  stack write data
- stk_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (either form): PC=0, MAR=0, SP=SP_INIT, stk_err=0. Asynchronous reset takes effect immediately, including mid-instruction.
- Load source: in all loads below, the load value is data_in[ADDR_W-1:0], the operand field of the instruction or the stacked word.
- PC next-state, highest priority first:
  - PC_LOAD(3): PC <= load value.
  - JUMP(19): PC <= PC+2 (skip the next word).
  - PC_INC(2): PC <= PC+1.
  - otherwise hold.
- MAR next-state, highest priority first:
  - MAR_LOAD(8): MAR <= load value.
  - MAR_A_LOAD(18): MAR <= a_in[ADDR_W-1:0].
  - MAR_STACK(11): MAR <= SP.
  - PC_MAR_LOAD(13): MAR <= PC (pre-edge value).
  - JUMP(19): MAR <= MAR+2.
  - MAR_INC(14): MAR <= MAR+1.
  - otherwise hold.
- All increments wrap modulo 2^ADDR_W. No flag is raised on PC or MAR wrap.
- Stack push, STACK_LOAD(12):
  - stk_we=1 in the same cycle; stk_addr = SP-1.
  - stk_wdata = MAR_EN(4) ? zero-extended MAR (pre-edge value, i.e. the return address) : a_in.
  - SP <= SP-1 at posedge.
- Stack pop, SP_ADD(10): SP <= SP+1. Data returns via the MAR_STACK fetch already performed by the controller.
- STACK_LOAD and SP_ADD together: SP holds, stk_we is still asserted, stk_err is unaffected.
- CAL cycle (PC_MAR_LOAD + STACK_LOAD + MAR_EN): the old MAR is pushed and MAR <= PC in the same edge.
- RET cycle (MAR_LOAD + PC_LOAD + PC_MAR_LOAD + SP_ADD): MAR_LOAD wins, so PC = MAR = popped address.
- mar_out, pc_out and sp_out are register outputs with zero combinational path from ctrl.
- Control bits not listed above (15–17, 20, 0, 1, 5–7, 9) are ignored.
- soft_rst has priority over every ctrl bit in the same cycle.

Optional Feature:
- STACK_CHECK_EN defined:
  - Push when SP == SP_INIT-STACK_DEPTH (mod) is overflow: stk_we forced 0, SP holds, stk_err <= 1.
  - Pop when SP == SP_INIT is underflow: SP holds, stk_err <= 1.
  - stk_err stays set until reset.
- Not defined: SP wraps freely modulo 2^ADDR_W, no write suppression, stk_err tied 0.

Test Plan:
- Fetch: PC=5, ctrl PC_INC+MAR_INC for 3 cycles -> PC=8, MAR=8; no stack activity.
- Jump: data_in=16'hB123, ctrl PC_LOAD+MAR_LOAD+PC_INC+MAR_INC -> PC=MAR=12'h123 (load beats increment).
- CAL/RET: MAR=12'h041, PC=12'h200, SP=0. CAL cycle (PC_MAR_LOAD+STACK_LOAD+MAR_EN) -> stk_we=1, stk_addr=12'hFFF, stk_wdata=16'h0041, SP=12'hFFF, MAR=12'h200. RET with data_in=16'h0041 -> PC=MAR=12'h041, SP=0.
- Skip: PC=10, MAR=10, ctrl JUMP+PC_INC+MAR_INC -> PC=12, MAR=12. PC=12'hFFF with JUMP -> PC=1.
- Bounds (STACK_CHECK_EN, STACK_DEPTH=2): 3 pushes of a_in=16'hAAAA -> 2 writes to FFF, FFE; third push has stk_we=0, SP=FFE, stk_err=1. Separately, pop at SP=0 -> SP=0, stk_err=1.
- Resets: reset low mid-CAL (asynchronous, between edges) -> PC/MAR/SP/stk_err at reset values immediately. soft_rst together with PC_LOAD -> PC=0.
